instr_split_queue: RTL

INSTR_SPLIT_QUEUE -- requirements
Module: instr_split_queue

---
 rtl/instr_split_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_split_queue.sv
// First-word-fall-through instruction queue that decodes MIPS-style fields from the head entry.
// Each entry holds {instr, pc}. The decode outputs are zeroed whenever the queue is empty.
module instr_split_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               out_opcode,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_shamt,
    output logic [5:0]               out_func,
    output logic [31:0]              out_imm_ext,
    output logic [31:0]              out_jump_target,
    output logic [31:0]              out_pc,
    output logic                     out_is_rtype,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push;
    logic          pop;

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset: reset and flush only move the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_instr, in_pc};
        end
    end

    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [31:0] imm_ext;

    assign head_instr = mem[rd_ptr_q][63:32];
    assign head_pc    = mem[rd_ptr_q][31:0];
    assign pc_plus4   = head_pc + 32'd4;
    assign opcode     = head_instr[31:26];

    always_comb begin
        imm_ext = {{16{head_instr[15]}}, head_instr[15:0]};
        case (opcode)
            6'h0F:               imm_ext = {head_instr[15:0], 16'h0000};
            6'h0C, 6'h0D, 6'h0E: imm_ext = {16'h0000, head_instr[15:0]};
            default:             imm_ext = {{16{head_instr[15]}}, head_instr[15:0]};
        endcase
    end

    always_comb begin
        out_opcode      = '0;
        out_rs          = '0;
        out_rt          = '0;
        out_rd          = '0;
        out_shamt       = '0;
        out_func        = '0;
        out_imm_ext     = '0;
        out_jump_target = '0;
        out_pc          = '0;
        out_is_rtype    = 1'b0;
        if (out_valid) begin
            out_opcode      = opcode;
            out_rs          = head_instr[25:21];
            out_rt          = head_instr[20:16];
            out_rd          = head_instr[15:11];
            out_shamt       = head_instr[10:6];
            out_func        = head_instr[5:0];
            out_imm_ext     = imm_ext;
            out_jump_target = {pc_plus4[31:28], head_instr[25:0], 2'b00};
            out_pc          = head_pc;
            out_is_rtype    = (opcode == 6'h00);
        end
    end

endmodule
